// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 16-bit 5-stage pipeline.
//   Covers three hazard sources:
//     - load-use hazards
//     - multi-cycle branch flushes
//     - data-memory wait states
//   It also flushes the pipeline after reset.
//   All control outputs are combinational from the registered state, the
//   down-counter and the current-cycle inputs, so a hazard acts in the same
//   cycle it is seen.
//
// Ports
//   clk, reset (async, active-low)
//   Decode stage:
//     dec_valid, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2
//   Execute stage:
//     ex_mem_read, ex_rd, branch_taken
//   Data memory:
//     mem_ready
//   Outputs:
//     pc_stall, fd_stall
//     fd_flush   00 pass, 01 branch flush, 10 startup flush
//     de_bubble, ex_stall
//     state_o    debug view of the FSM state
//
// Optional build macro HAZARD_PERF_EN adds two counters. Both saturate at
// 16'hFFFF and clear on reset.
//   perf_stall_cnt   cycles with pc_stall high
//   perf_flush_cnt   cycles with fd_flush == 01
module pipeline_hazard_ctrl #(
  parameter int REG_W          = 4,
  parameter int FLUSH_CYCLES   = 2,
  parameter int STARTUP_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_rs1,
  input  logic [REG_W-1:0] dec_rs2,
  input  logic             dec_uses_rs1,
  input  logic             dec_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             fd_stall,
  output logic [1:0]       fd_flush,
  output logic             de_bubble,
  output logic             ex_stall,
  output logic [2:0]       state_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]      perf_stall_cnt,
  output logic [15:0]      perf_flush_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_STARTUP    = 3'd0,
    ST_RUN        = 3'd1,
    ST_LOAD_STALL = 3'd2,
    ST_BR_FLUSH   = 3'd3,
    ST_MEM_WAIT   = 3'd4
  } state_t;

  localparam logic [2:0] STARTUP_LOAD = 3'(STARTUP_CYCLES - 1);
  localparam logic [2:0] FLUSH_LOAD   = 3'((FLUSH_CYCLES >= 2) ? FLUSH_CYCLES - 2 : 0);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pend_br_q, pend_br_d;
  logic       load_use;
  logic       take_br;

  assign load_use = ex_mem_read && (ex_rd != '0) && dec_valid &&
                    ((dec_uses_rs1 && (dec_rs1 == ex_rd)) ||
                     (dec_uses_rs2 && (dec_rs2 == ex_rd)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_STARTUP;
      cnt_q     <= STARTUP_LOAD;
      pend_br_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_br_q <= pend_br_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_br_d = pend_br_q;
    take_br   = 1'b0;
    pc_stall  = 1'b0;
    fd_stall  = 1'b0;
    fd_flush  = 2'b00;
    de_bubble = 1'b0;
    ex_stall  = 1'b0;

    case (state_q)
      ST_STARTUP: begin
        fd_flush  = 2'b10;
        de_bubble = 1'b1;
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - 3'd1;
      end
      // LOAD_STALL shares RUN's priority chain but never re-detects the
      // same load-use, so each load-use costs exactly one bubble.
      ST_RUN, ST_LOAD_STALL: begin
        if (branch_taken) begin
          take_br = 1'b1;
        end else if (!mem_ready) begin
          pc_stall = 1'b1;
          fd_stall = 1'b1;
          ex_stall = 1'b1;
          state_d  = ST_MEM_WAIT;
        end else if (load_use && (state_q == ST_RUN)) begin
          pc_stall  = 1'b1;
          fd_stall  = 1'b1;
          de_bubble = 1'b1;
          state_d   = ST_LOAD_STALL;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_BR_FLUSH: begin
        fd_flush  = 2'b01;
        de_bubble = 1'b1;
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - 3'd1;
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          pc_stall  = 1'b1;
          fd_stall  = 1'b1;
          ex_stall  = 1'b1;
          // A branch resolving while memory is stalled is remembered and
          // its flush starts on the cycle the wait ends.
          pend_br_d = pend_br_q | branch_taken;
        end else if (pend_br_q || branch_taken) begin
          take_br = 1'b1;
        end else begin
          state_d   = ST_RUN;
          pend_br_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_STARTUP;
        cnt_d     = STARTUP_LOAD;
        pend_br_d = 1'b0;
      end
    endcase

    // The taken-branch cycle is itself the first flush cycle.
    if (take_br) begin
      fd_flush  = 2'b01;
      de_bubble = 1'b1;
      pend_br_d = 1'b0;
      if (FLUSH_CYCLES == 1) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_BR_FLUSH;
        cnt_d   = FLUSH_LOAD;
      end
    end
  end

  assign state_o = state_q;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if ((fd_flush == 2'b01) && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed vectors with literal
// expectations, plus a cycle-level model of the hazard rules checked on
// every falling clock edge.
module tb_pipeline_hazard_ctrl;

  localparam int REG_W          = 4;
  localparam int FLUSH_CYCLES   = 2;
  localparam int STARTUP_CYCLES = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             dec_valid, dec_uses_rs1, dec_uses_rs2;
  logic [REG_W-1:0] dec_rs1, dec_rs2, ex_rd;
  logic             ex_mem_read, branch_taken, mem_ready;
  logic             pc_stall, fd_stall, de_bubble, ex_stall;
  logic [1:0]       fd_flush;
  logic [2:0]       state_o;
`ifdef HAZARD_PERF_EN
  logic [15:0]      perf_stall_cnt, perf_flush_cnt;
`endif

  int vectors    = 0;
  int miscompares = 0;

  pipeline_hazard_ctrl #(
    .REG_W(REG_W), .FLUSH_CYCLES(FLUSH_CYCLES), .STARTUP_CYCLES(STARTUP_CYCLES)
  ) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .fd_stall(fd_stall), .fd_flush(fd_flush),
    .de_bubble(de_bubble), .ex_stall(ex_stall), .state_o(state_o)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // {pc_stall, fd_stall, fd_flush[1:0], de_bubble, ex_stall}
  wire [5:0] outs = {pc_stall, fd_stall, fd_flush, de_bubble, ex_stall};
  localparam logic [5:0] O_NONE  = 6'b000000;
  localparam logic [5:0] O_START = 6'b001010;
  localparam logic [5:0] O_FLUSH = 6'b000110;
  localparam logic [5:0] O_MEM   = 6'b110001;
  localparam logic [5:0] O_LU    = 6'b110010;

  // ---------------- behavioural model ----------------
  // Remaining-cycle counters for the startup and branch-flush windows, plus
  // flags for an ongoing memory wait, a remembered branch, and "the previous
  // cycle already inserted a load-use bubble".
  int startup_left = STARTUP_CYCLES;
  int flush_left   = 0;
  bit mem_wait     = 0;
  bit pend         = 0;
  bit just_bubbled = 0;
  int m_stall_cnt  = 0;
  int m_flush_cnt  = 0;

  function automatic bit hazard();
    return ex_mem_read && (ex_rd != 0) && dec_valid &&
           ((dec_uses_rs1 && dec_rs1 == ex_rd) || (dec_uses_rs2 && dec_rs2 == ex_rd));
  endfunction

  // 0 idle, 1 startup, 2 flush continuation, 3 memory stall, 4 load-use, 5 new branch
  function automatic int action();
    if (!reset || startup_left > 0) return 1;
    if (flush_left > 0) return 2;
    if (mem_wait) begin
      if (!mem_ready) return 3;
      if (pend || branch_taken) return 5;
      return 0;
    end
    if (branch_taken) return 5;
    if (!mem_ready) return 3;
    if (hazard() && !just_bubbled) return 4;
    return 0;
  endfunction

  function automatic logic [5:0] exp_outs(input int a);
    case (a)
      1:       return O_START;
      2, 5:    return O_FLUSH;
      3:       return O_MEM;
      4:       return O_LU;
      default: return O_NONE;
    endcase
  endfunction

  function automatic logic [2:0] exp_state();
    if (!reset || startup_left > 0) return 3'd0;
    if (flush_left > 0) return 3'd3;
    if (mem_wait) return 3'd4;
    if (just_bubbled) return 3'd2;
    return 3'd1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      startup_left = STARTUP_CYCLES; flush_left = 0; mem_wait = 0; pend = 0;
      just_bubbled = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      int a;
      a = action();
      if ((a == 3 || a == 4) && m_stall_cnt < 65535) m_stall_cnt++;
      if ((a == 2 || a == 5) && m_flush_cnt < 65535) m_flush_cnt++;
      case (a)
        1: startup_left--;
        2: flush_left--;
        3: begin if (mem_wait && branch_taken) pend = 1; mem_wait = 1; end
        5: begin flush_left = FLUSH_CYCLES - 1; pend = 0; mem_wait = 0; end
        4: ;
        default: begin mem_wait = 0; pend = 0; end
      endcase
      just_bubbled = (a == 4);
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic [5:0] e;
    logic [2:0] s;
    e = exp_outs(action());
    s = exp_state();
    vectors++;
    if (outs !== e) begin
      miscompares++;
      $display("FAIL model_outs t=%0t: got %b expected %b", $time, outs, e);
    end
    vectors++;
    if (state_o !== s) begin
      miscompares++;
      $display("FAIL model_state t=%0t: got %0d expected %0d", $time, state_o, s);
    end
`ifdef HAZARD_PERF_EN
    vectors++;
    if (perf_stall_cnt !== 16'(m_stall_cnt) || perf_flush_cnt !== 16'(m_flush_cnt)) begin
      miscompares++;
      $display("FAIL model_perf t=%0t: got %0d/%0d expected %0d/%0d", $time,
               perf_stall_cnt, perf_flush_cnt, m_stall_cnt, m_flush_cnt);
    end
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic lit(input string nm, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic clear_in();
    dec_valid = 0; dec_rs1 = '0; dec_rs2 = '0; dec_uses_rs1 = 0; dec_uses_rs2 = 0;
    ex_mem_read = 0; ex_rd = '0; branch_taken = 0; mem_ready = 1;
  endtask

  task automatic set_lu(input logic [REG_W-1:0] rd);
    ex_mem_read = 1; ex_rd = rd; dec_rs2 = 4'd3; dec_uses_rs2 = 1; dec_valid = 1;
  endtask

  // Table of load-use patterns: valid, rs1, rs2, uses1, uses2, mem_read, rd, expected stall
  logic       t_v  [6] = '{1, 1, 0, 1, 1, 1};
  logic [3:0] t_r1 [6] = '{5, 5, 5, 5, 0, 4};
  logic [3:0] t_r2 [6] = '{0, 0, 0, 0, 15, 6};
  logic       t_u1 [6] = '{1, 0, 1, 1, 0, 1};
  logic       t_u2 [6] = '{0, 0, 0, 0, 1, 1};
  logic       t_mr [6] = '{1, 1, 1, 0, 1, 1};
  logic [3:0] t_rd [6] = '{5, 5, 5, 5, 15, 7};
  logic       t_ex [6] = '{1, 0, 0, 0, 1, 0};

  initial begin
    reset = 0;
    clear_in();
    tick(); tick();
    lit("reset_flush", 16'(fd_flush), 16'h2);
    lit("reset_bubble", 16'(de_bubble), 16'h1);
    lit("reset_stalls", 16'({pc_stall, fd_stall, ex_stall}), 16'h0);
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      lit("startup_flush", 16'(outs), 16'(O_START));
      tick();
    end
    at_neg();
    lit("run_state", 16'(state_o), 16'h1);
    lit("run_outs", 16'(outs), 16'h0);

    // load-use: one bubble, then LOAD_STALL masks it, then RUN
    tick(); set_lu(4'd3);
    at_neg(); lit("lu_stall", 16'(outs), 16'(O_LU));
    tick();
    at_neg(); lit("lu_masked_outs", 16'(outs), 16'h0); lit("lu_masked_state", 16'(state_o), 16'h2);
    tick(); clear_in();
    at_neg(); lit("lu_back_run", 16'(state_o), 16'h1);
    tick(); set_lu(4'd0); dec_rs2 = 4'd0;
    at_neg(); lit("lu_r0", 16'(outs), 16'h0);
    tick(); clear_in();

    // taken branch: exactly two flush cycles, second pulse ignored
    tick(); branch_taken = 1;
    at_neg(); lit("br_flush1", 16'(outs), 16'(O_FLUSH));
    tick(); branch_taken = 1;
    at_neg(); lit("br_flush2", 16'(outs), 16'(O_FLUSH)); lit("br_state", 16'(state_o), 16'h3);
    tick(); branch_taken = 0;
    at_neg(); lit("br_done", 16'(outs), 16'h0); lit("br_done_state", 16'(state_o), 16'h1);

    // memory wait 4 cycles, branch pulsed in wait cycle 2
    tick(); mem_ready = 0;
    at_neg(); lit("mem_w1", 16'(outs), 16'(O_MEM));
    tick(); branch_taken = 1;
    at_neg(); lit("mem_w2", 16'(outs), 16'(O_MEM));
    tick(); branch_taken = 0;
    at_neg(); lit("mem_w3", 16'(outs), 16'(O_MEM));
    tick();
    at_neg(); lit("mem_w4", 16'(outs), 16'(O_MEM));
    tick(); mem_ready = 1;
    at_neg(); lit("mem_pend_flush1", 16'(outs), 16'(O_FLUSH));
    tick();
    at_neg(); lit("mem_pend_flush2", 16'(outs), 16'(O_FLUSH));
    tick();
    at_neg(); lit("mem_run", 16'(state_o), 16'h1); lit("mem_run_outs", 16'(outs), 16'h0);

    // branch beats memory and load-use in the same cycle
    tick(); branch_taken = 1; mem_ready = 0; set_lu(4'd3);
    at_neg(); lit("prio_outs", 16'(outs), 16'(O_FLUSH)); lit("prio_pc_stall", 16'(pc_stall), 16'h0);
    tick(); clear_in();
    at_neg(); lit("prio_state", 16'(state_o), 16'h3);
    tick();

    // branch taken while in LOAD_STALL
    tick(); set_lu(4'd3);
    at_neg(); lit("ls_stall", 16'(outs), 16'(O_LU));
    tick(); branch_taken = 1;
    at_neg(); lit("ls_branch", 16'(outs), 16'(O_FLUSH));
    tick(); clear_in();
    tick();
    at_neg(); lit("ls_run", 16'(state_o), 16'h1);

    // load-use pattern table
    for (int i = 0; i < 6; i++) begin
      tick();
      dec_valid = t_v[i]; dec_rs1 = t_r1[i]; dec_rs2 = t_r2[i];
      dec_uses_rs1 = t_u1[i]; dec_uses_rs2 = t_u2[i]; ex_mem_read = t_mr[i]; ex_rd = t_rd[i];
      at_neg();
      lit($sformatf("tbl%0d_pc_stall", i), 16'(pc_stall), 16'(t_ex[i]));
      lit($sformatf("tbl%0d_bubble", i), 16'(de_bubble), 16'(t_ex[i]));
      tick(); clear_in();
      tick();
    end

    // asynchronous reset in the middle of a memory wait
    tick(); mem_ready = 0;
    tick(); reset = 0; #1;
    lit("midrst_state", 16'(state_o), 16'h0);
    lit("midrst_outs", 16'(outs), 16'(O_START));
    tick(); reset = 1; mem_ready = 1;
    for (int i = 0; i < 3; i++) tick();
    at_neg(); lit("midrst_run", 16'(state_o), 16'h1);

`ifdef HAZARD_PERF_EN
    tick(); reset = 0; #1;
    lit("perf_clr_stall", perf_stall_cnt, 16'h0);
    tick(); reset = 1;
    for (int i = 0; i < 3; i++) tick();
    mem_ready = 0;
    repeat (70000) tick();
    at_neg(); lit("perf_sat", perf_stall_cnt, 16'hFFFF);
    tick(); reset = 0; #1;
    lit("perf_reset", perf_stall_cnt, 16'h0);
    tick(); reset = 1; mem_ready = 1;
    for (int i = 0; i < 4; i++) tick();
`endif

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
